// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared state encodings and length-parameter legality check
package axis_pkg;

    localparam logic [0:0] ST_PASS    = 1'b0;
    localparam logic [0:0] ST_DISCARD = 1'b1;

    function automatic bit len_cfg_ok(input int min_len, input int max_len, input int len_width);
        return (min_len >= 1) && (max_len >= min_len) &&
               (64'(max_len) < (64'd1 << len_width));
    endfunction

endpackage

`define AXIS_LEN_LEGAL(MN, MX, W) (axis_pkg::len_cfg_ok((MN), (MX), (W)))

// File: rtl/axis_if.sv
// rtl/axis_if.sv - AXI-stream beat bundle with source/sink modports
interface axis_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// rtl/axis_out_reg.sv - single output register stage driving an AXI-stream master
module axis_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] d_data,
    input  logic                  d_last,
    input  logic                  d_user,
    axis_if.master                m
);

    // Payload only changes on a real load, so a stalled beat stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m.tvalid <= 1'b0;
            m.tdata  <= '0;
            m.tlast  <= 1'b0;
            m.tuser  <= 1'b0;
        end else if (load_en) begin
            m.tvalid <= load_valid;
            if (load_valid) begin
                m.tdata <= d_data;
                m.tlast <= d_last;
                m.tuser <= d_user;
            end
        end
    end

endmodule

// File: rtl/axis_frame_len_check.sv
// rtl/axis_frame_len_check.sv - in-line frame length checker: flags undersize, truncates oversize
module axis_frame_len_check
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int MIN_LEN    = 4,
    parameter int MAX_LEN    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_if.slave                input_axis,
    axis_if.master               output_axis,
    output logic [LEN_WIDTH-1:0] frame_len,
    output logic                 frame_done,
    output logic                 err_undersize,
    output logic                 err_oversize
);

    generate
        if (!`AXIS_LEN_LEGAL(MIN_LEN, MAX_LEN, LEN_WIDTH)) begin : g_bad_cfg
            $error("axis_frame_len_check: illegal MIN_LEN/MAX_LEN/LEN_WIDTH");
        end
    endgenerate

    logic [0:0]           state;
    logic [LEN_WIDTH-1:0] cnt;
    logic [LEN_WIDTH-1:0] n;
    logic                 bad;
    logic                 load_en;
    logic                 accept;
    logic                 pass_beat;
    logic                 under;
    logic                 at_max;
    logic                 out_last;
    logic                 out_user;

    assign load_en = ~output_axis.tvalid | output_axis.tready;
    // Held low through reset; DISCARD swallows beats regardless of the output side.
    assign input_axis.tready = ~rst & ((state == ST_DISCARD) | load_en);
    assign accept    = input_axis.tvalid & input_axis.tready;
    assign pass_beat = accept & (state == ST_PASS);
    assign n         = cnt + LEN_WIDTH'(1);
    assign under     = n < LEN_WIDTH'(MIN_LEN);
    assign at_max    = n == LEN_WIDTH'(MAX_LEN);

    // tlast wins over the MAX_LEN cut, so an exactly-MAX_LEN frame stays clean.
    always_comb begin
        out_last = input_axis.tlast | at_max;
        out_user = 1'b0;
        if (input_axis.tlast) out_user = bad | input_axis.tuser | under;
        else if (at_max)      out_user = 1'b1;
    end

    axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_valid (pass_beat),
        .d_data     (input_axis.tdata),
        .d_last     (out_last),
        .d_user     (out_user),
        .m          (output_axis)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_PASS;
            cnt           <= '0;
            bad           <= 1'b0;
            frame_len     <= '0;
            frame_done    <= 1'b0;
            err_undersize <= 1'b0;
            err_oversize  <= 1'b0;
        end else begin
            frame_done    <= 1'b0;
            err_undersize <= 1'b0;
            err_oversize  <= 1'b0;
            if (accept) begin
                if (state == ST_PASS) begin
                    if (input_axis.tlast) begin
                        frame_len     <= n;
                        frame_done    <= 1'b1;
                        err_undersize <= under;
                        cnt           <= '0;
                        bad           <= 1'b0;
                    end else if (at_max) begin
                        frame_len    <= LEN_WIDTH'(MAX_LEN);
                        frame_done   <= 1'b1;
                        err_oversize <= 1'b1;
                        cnt          <= '0;
                        bad          <= 1'b0;
                        state        <= ST_DISCARD;
                    end else begin
                        cnt <= n;
                        bad <= bad | input_axis.tuser;
                    end
                end else if (input_axis.tlast) begin
                    state <= ST_PASS;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_len_check.sv
// tb/tb_axis_frame_len_check.sv - scoreboard bench for axis_frame_len_check
module tb_axis_frame_len_check;

    localparam int DW   = 8;
    localparam int LW   = 16;
    localparam int MINL = 4;
    localparam int MAXL = 8;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    typedef struct {
        logic [15:0] len;
        logic        un;
        logic        ov;
    } stat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LW-1:0] frame_len;
    logic          frame_done;
    logic          err_undersize;
    logic          err_oversize;
    bit            toggle_mode = 1'b0;

    beat_t exp_beats[$];
    stat_t exp_stats[$];
    int    total = 0;
    int    bad   = 0;

    axis_if #(.DATA_WIDTH(DW)) in_if ();
    axis_if #(.DATA_WIDTH(DW)) out_if ();

    axis_frame_len_check #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .MIN_LEN    (MINL),
        .MAX_LEN    (MAXL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .input_axis    (in_if),
        .output_axis   (out_if),
        .frame_len     (frame_len),
        .frame_done    (frame_done),
        .err_undersize (err_undersize),
        .err_oversize  (err_oversize)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic l, input logic u);
        int k;
        @(negedge clk);
        in_if.tvalid = 1'b1;
        in_if.tdata  = d;
        in_if.tlast  = l;
        in_if.tuser  = u;
        #1;
        k = 0;
        while (!in_if.tready && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 200) check("accept_timeout", 32'(in_if.tready), 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] start, input int n, input int user_beat);
        beat_t b;
        stat_t s;
        int    nout;
        bit    any_user;
        nout     = (n > MAXL) ? MAXL : n;
        any_user = (user_beat >= 0) && (user_beat < nout);
        for (int i = 0; i < nout; i++) begin
            b.d = start + 8'(i);
            b.l = (i == nout - 1);
            b.u = b.l && ((n > MAXL) || any_user || (n < MINL));
            exp_beats.push_back(b);
        end
        s.len = 16'(nout);
        s.un  = (n < MINL);
        s.ov  = (n > MAXL);
        exp_stats.push_back(s);
        for (int i = 0; i < n; i++)
            drive_beat(start + 8'(i), (i == n - 1), (i == user_beat));
        @(negedge clk);
        in_if.tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_beats.size() != 0 || exp_stats.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(exp_beats.size() + exp_stats.size()), 32'd0);
    endtask

    initial begin
        out_if.tready = 1'b1;
        forever begin
            @(negedge clk);
            out_if.tready = toggle_mode ? ~out_if.tready : 1'b1;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a beat or a status pulse.
    initial begin
        bit    prev_stall;
        beat_t prev;
        beat_t e;
        stat_t s;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", {out_if.tvalid, out_if.tdata, out_if.tlast, out_if.tuser},
                          {1'b1, prev.d, prev.l, prev.u});
                if (out_if.tvalid && out_if.tready) begin
                    if (exp_beats.size() == 0) begin
                        check("unexpected_beat", {out_if.tdata, out_if.tlast, out_if.tuser}, 32'hffff_ffff);
                    end else begin
                        e = exp_beats.pop_front();
                        check("beat", {out_if.tdata, out_if.tlast, out_if.tuser}, {e.d, e.l, e.u});
                    end
                end
                prev_stall = out_if.tvalid && !out_if.tready;
                prev.d = out_if.tdata;
                prev.l = out_if.tlast;
                prev.u = out_if.tuser;
                if (frame_done) begin
                    if (exp_stats.size() == 0) begin
                        check("unexpected_done", {frame_len, err_undersize, err_oversize}, 32'hffff_ffff);
                    end else begin
                        s = exp_stats.pop_front();
                        check("status", {frame_len, err_undersize, err_oversize}, {s.len, s.un, s.ov});
                    end
                end else if (err_undersize || err_oversize) begin
                    check("stray_err", {err_undersize, err_oversize}, 32'd0);
                end
            end
        end
    end

    initial begin
        beat_t b;
        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        in_if.tlast  = 1'b0;
        in_if.tuser  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_if.tvalid), 32'd0);
        check("rst_in_ready", 32'(in_if.tready), 32'd0);
        check("rst_status", {frame_len, frame_done, err_undersize, err_oversize}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        send_frame(8'h01, 5, -1);
        send_frame(8'h30, 2, -1);
        send_frame(8'h10, 11, -1);
        send_frame(8'h40, 4, -1);
        send_frame(8'h50, 8, -1);
        send_frame(8'h60, 6, 1);
        drain("drain_plain");

        toggle_mode = 1'b1;
        send_frame(8'h70, 6, 1);
        drain("drain_stall");
        toggle_mode = 1'b0;
        repeat (2) @(negedge clk);

        // Partial frame cut by reset: only the first two beats get presented before reset.
        for (int i = 0; i < 2; i++) begin
            b.d = 8'h90 + 8'(i);
            b.l = 1'b0;
            b.u = 1'b0;
            exp_beats.push_back(b);
        end
        for (int i = 0; i < 3; i++) drive_beat(8'h90 + 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        in_if.tvalid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_out", {out_if.tvalid, out_if.tdata, out_if.tlast, out_if.tuser}, 32'd0);
        check("mid_rst_status", {frame_len, frame_done, in_if.tready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'h80, 4, -1);
        drain("drain_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
